// File: rtl/jls_stream_parser.sv
// JPEG-LS .jls byte-stream reader: parses SOI/SOF55/SOS, strips scan bit stuffing, repacks bytes.
// Optional macro JLS_PARSER_SKIP_EN accepts LSE/COM/APPn segments before SOS and discards them.
`timescale 1ns/1ps
module jls_stream_parser #(
   parameter int unsigned MAXLEN_LEVEL = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ivalid,
   input  logic                    ilast,
   input  logic [7:0]              idata,
   output logic                    onew,
   output logic [MAXLEN_LEVEL-1:0] owidth,
   output logic [15:0]             oheight,
   output logic [7:0]              onear,
   output logic                    ovalid,
   output logic [7:0]              odata,
   output logic                    olast,
   output logic [3:0]              onbits,
   output logic                    oerror
);
   localparam int unsigned XMax = (1 << MAXLEN_LEVEL) - 1;

   typedef enum logic [3:0] {
      StSoi0, StSoi1, StMff, StMcode, StLenh, StLenl, StBody, StScan, StScanFf, StFlush, StDrain
   } state_e;
   typedef enum logic [1:0] {SegSof, SegSos, SegSkip} seg_e;

   state_e                  state_q;
   seg_e                    seg_q;
   logic                    sof_seen_q, eoi_last_q;
   logic [7:0]              lenh_q, hi_q;
   logic [15:0]             blen_q, off_q;
   logic [15:0]             acc_q;   // MSB-aligned pending scan bits
   logic [3:0]              cnt_q;
   logic                    onew_q, ovalid_q, olast_q, oerror_q;
   logic [7:0]              odata_q, onear_q;
   logic [3:0]              onbits_q;
   logic [MAXLEN_LEVEL-1:0] owidth_q;
   logic [15:0]             oheight_q;

   logic        skip_code, fail, emit;
   logic [15:0] seg_len, word;
   logic [14:0] app_bits;
   logic [4:0]  app_n, merged_n;
   logic [23:0] merged;

`ifdef JLS_PARSER_SKIP_EN
   assign skip_code = (idata == 8'hF8) || (idata == 8'hFE) || (idata[7:4] == 4'hE);
`else
   assign skip_code = 1'b0;
`endif

   assign seg_len = {lenh_q, idata};
   assign word    = {hi_q, idata};

   // Incoming scan bits are merged with held bits before deciding whether a byte goes out.
   always_comb begin
      app_n    = 5'd0;
      app_bits = 15'h0;
      if (ivalid && !ilast) begin
         if (state_q == StScan && idata != 8'hFF) begin
            app_n    = 5'd8;
            app_bits = {idata, 7'h00};
         end else if (state_q == StScanFf && !idata[7]) begin
            app_n    = 5'd15;
            app_bits = {8'hFF, idata[6:0]};
         end
      end
      merged   = {acc_q, 8'h00} | ({app_bits, 9'h000} >> cnt_q);
      merged_n = {1'b0, cnt_q} + app_n;
      emit     = merged_n >= 5'd8;
   end

   always_comb begin
      fail = 1'b0;
      if (ivalid && state_q != StDrain && state_q != StFlush) begin
         if (ilast && !(state_q == StScanFf && idata == 8'hD9)) fail = 1'b1;
         case (state_q)
            StSoi0:   if (idata != 8'hFF) fail = 1'b1;
            StSoi1:   if (idata != 8'hD8) fail = 1'b1;
            StMff:    if (idata != 8'hFF) fail = 1'b1;
            StMcode:  if (!(idata == 8'hF7 || (idata == 8'hDA && sof_seen_q) || skip_code))
                         fail = 1'b1;
            StLenl:   if (seg_len < 16'd2 || (seg_q == SegSof && seg_len < 16'd8) ||
                          (seg_q == SegSos && seg_len < 16'd6)) fail = 1'b1;
            StBody: begin
               if (seg_q == SegSof) begin
                  case (off_q)
                     16'd0:   if (idata != 8'd8) fail = 1'b1;
                     16'd2:   if (word == 16'd0) fail = 1'b1;
                     16'd4:   if (word < 16'd4 || 32'(word) > XMax) fail = 1'b1;
                     16'd5:   if (idata != 8'd1) fail = 1'b1;
                     default: ;
                  endcase
               end else if (seg_q == SegSos && off_q == 16'd0 && idata != 8'd1) begin
                  fail = 1'b1;
               end
            end
            StScanFf: if (idata[7] && idata != 8'hD9) fail = 1'b1;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StSoi0;
         seg_q      <= SegSof;
         sof_seen_q <= 1'b0;
         eoi_last_q <= 1'b0;
         lenh_q     <= 8'h0;
         hi_q       <= 8'h0;
         blen_q     <= 16'h0;
         off_q      <= 16'h0;
         acc_q      <= 16'h0;
         cnt_q      <= 4'd0;
         onew_q     <= 1'b0;
         ovalid_q   <= 1'b0;
         olast_q    <= 1'b0;
         oerror_q   <= 1'b0;
         odata_q    <= 8'h0;
         onbits_q   <= 4'd0;
         onear_q    <= 8'h0;
         owidth_q   <= '0;
         oheight_q  <= 16'h0;
      end else begin
         onew_q   <= 1'b0;
         ovalid_q <= 1'b0;
         olast_q  <= 1'b0;
         oerror_q <= 1'b0;
         odata_q  <= 8'h0;
         onbits_q <= 4'd0;
         if (fail) begin
            // Bits beyond one byte are dropped: the scan is unusable anyway.
            ovalid_q <= 1'b1;
            olast_q  <= 1'b1;
            oerror_q <= 1'b1;
            odata_q  <= acc_q[15:8];
            onbits_q <= (cnt_q > 4'd8) ? 4'd8 : cnt_q;
            acc_q    <= 16'h0;
            cnt_q    <= 4'd0;
            state_q  <= ilast ? StSoi0 : StDrain;
         end else if (state_q == StFlush) begin
            ovalid_q <= 1'b1;
            odata_q  <= acc_q[15:8];
            if (cnt_q >= 4'd8) begin
               onbits_q <= 4'd8;
               acc_q    <= {acc_q[7:0], 8'h00};
               cnt_q    <= cnt_q - 4'd8;
            end else begin
               olast_q  <= 1'b1;
               onbits_q <= cnt_q;
               acc_q    <= 16'h0;
               cnt_q    <= 4'd0;
               state_q  <= eoi_last_q ? StSoi0 : StDrain;
            end
         end else begin
            if (emit) begin
               ovalid_q <= 1'b1;
               odata_q  <= merged[23:16];
               onbits_q <= 4'd8;
               acc_q    <= merged[15:0];
               cnt_q    <= 4'(merged_n - 5'd8);
            end else begin
               acc_q <= merged[23:8];
               cnt_q <= merged_n[3:0];
            end
            if (ivalid) begin
               case (state_q)
                  StSoi0:  state_q <= StSoi1;
                  StSoi1: begin
                     sof_seen_q <= 1'b0;
                     state_q    <= StMff;
                  end
                  StMff:   state_q <= StMcode;
                  StMcode: begin
                     seg_q   <= (idata == 8'hF7) ? SegSof : (idata == 8'hDA) ? SegSos : SegSkip;
                     state_q <= StLenh;
                  end
                  StLenh: begin
                     lenh_q  <= idata;
                     state_q <= StLenl;
                  end
                  StLenl: begin
                     blen_q  <= seg_len - 16'd2;
                     off_q   <= 16'h0;
                     state_q <= (seg_len == 16'd2) ? StMff : StBody;
                  end
                  StBody: begin
                     if (seg_q == SegSof) begin
                        case (off_q)
                           16'd1, 16'd3: hi_q <= idata;
                           16'd2:        oheight_q <= word;
                           16'd4:        owidth_q <= word[MAXLEN_LEVEL-1:0];
                           default:      ;
                        endcase
                     end
                     if (seg_q == SegSos && off_q == 16'd3) onear_q <= idata;
                     if (off_q == blen_q - 16'd1) begin
                        if (seg_q == SegSos) begin
                           onew_q  <= 1'b1;
                           state_q <= StScan;
                        end else begin
                           if (seg_q == SegSof) sof_seen_q <= 1'b1;
                           state_q <= StMff;
                        end
                     end else begin
                        off_q <= off_q + 16'd1;
                     end
                  end
                  StScan:  if (idata == 8'hFF) state_q <= StScanFf;
                  StScanFf: begin
                     if (idata == 8'hD9) begin
                        eoi_last_q <= ilast;
                        state_q    <= StFlush;
                     end else begin
                        state_q <= StScan;
                     end
                  end
                  StDrain: if (ilast) state_q <= StSoi0;
                  default: ;
               endcase
            end
         end
      end
   end

   assign onew    = onew_q;
   assign owidth  = owidth_q;
   assign oheight = oheight_q;
   assign onear   = onear_q;
   assign ovalid  = ovalid_q;
   assign odata   = odata_q;
   assign olast   = olast_q;
   assign onbits  = onbits_q;
   assign oerror  = oerror_q;
endmodule
